// File: rtl/zion_rvi_addsub_arb_if.sv
// Request/response bundle for the shared add/sub/compare arbiter.
// The master side is the requesters plus the result consumer; the slave side is the arbiter.
interface zion_rvi_addsub_arb_if #(
  parameter int CPU_WIDTH = 32,
  parameter int NUM_REQ   = 2,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]           req_vld;
  logic [NUM_REQ-1:0]           req_rdy;
  logic [2*NUM_REQ-1:0]         req_op;
  logic [NUM_REQ-1:0]           req_unsigned;
  logic [CPU_WIDTH*NUM_REQ-1:0] req_s1;
  logic [CPU_WIDTH*NUM_REQ-1:0] req_s2;
  logic                         rsp_vld;
  logic                         rsp_rdy;
  logic [ID_WIDTH-1:0]          rsp_id;
  logic [CPU_WIDTH-1:0]         rsp_rslt;
  logic                         rsp_lt;
  logic                         rsp_err;

  modport master (
    output req_vld, req_op, req_unsigned, req_s1, req_s2, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_id, rsp_rslt, rsp_lt, rsp_err
  );

  modport slave (
    input  req_vld, req_op, req_unsigned, req_s1, req_s2, rsp_rdy,
    output req_rdy, rsp_vld, rsp_id, rsp_rslt, rsp_lt, rsp_err
  );
endinterface

// File: rtl/zion_rvi_addsub_arb.sv
// Round-robin arbiter in front of one shared RV32 add/sub/less-than unit,
// with a single-entry result register released by a valid/ready handshake.
//
// state | meaning
// EMPTY | result register holds nothing, any granted request may fire
// FULL  | result register valid, new fire only alongside a pop
module zion_rvi_addsub_arb #(
  parameter int CPU_WIDTH = 32,
  parameter int NUM_REQ   = 2,
  parameter int CNT_WIDTH = 16,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  zion_rvi_addsub_arb_if.slave bus,
  output logic [CNT_WIDTH-1:0] op_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [ID_WIDTH-1:0]  gnt_id;
  logic                 any_vld;
  logic                 issue_en;
  logic                 fire;
  logic                 pop;

  logic [1:0]           sel_op;
  logic                 sel_uns;
  logic [CPU_WIDTH-1:0] sel_s1;
  logic [CPU_WIDTH-1:0] sel_s2;
  logic                 op_add;
  logic                 op_sub;
  logic [CPU_WIDTH-1:0] addend;
  logic [CPU_WIDTH:0]   sum;
  logic                 ovf;
  logic                 lt_nxt;
  logic [CPU_WIDTH-1:0] rslt_nxt;
  logic                 err_nxt;
  logic [ID_WIDTH-1:0]  ptr_nxt;

  // Search starts at rr_ptr and wraps upward; first valid requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_id  = '0;
    any_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_vld && bus.req_vld[idx]) begin
        any_vld    = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = ID_WIDTH'(idx);
      end
    end
  end

  assign issue_en    = (state == EMPTY) | bus.rsp_rdy;
  assign bus.req_rdy = grant & {NUM_REQ{issue_en}};
  assign fire        = any_vld & issue_en;
  assign pop         = (state == FULL) & bus.rsp_rdy;
  assign bus.rsp_vld = (state == FULL);

  assign sel_op  = bus.req_op[int'(gnt_id)*2 +: 2];
  assign sel_uns = bus.req_unsigned[gnt_id];
  assign sel_s1  = bus.req_s1[int'(gnt_id)*CPU_WIDTH +: CPU_WIDTH];
  assign sel_s2  = bus.req_s2[int'(gnt_id)*CPU_WIDTH +: CPU_WIDTH];
  assign op_add  = (sel_op == 2'b01);
  assign op_sub  = (sel_op == 2'b10);

  // One adder serves both ops: sub is s1 + ~s2 + 1, and less-than falls out of
  // its carry (unsigned borrow) or sign xor overflow (signed).
  assign addend = op_sub ? ~sel_s2 : sel_s2;
  assign sum    = {1'b0, sel_s1} + {1'b0, addend} + {{CPU_WIDTH{1'b0}}, op_sub};
  assign ovf    = (sel_s1[CPU_WIDTH-1] == addend[CPU_WIDTH-1]) &
                  (sum[CPU_WIDTH-1] != sel_s1[CPU_WIDTH-1]);

  assign lt_nxt   = op_sub & (sel_uns ? ~sum[CPU_WIDTH] : (sum[CPU_WIDTH-1] ^ ovf));
  assign rslt_nxt = (op_add | op_sub) ? sum[CPU_WIDTH-1:0] : '0;
  assign err_nxt  = ~(op_add | op_sub);
  assign ptr_nxt  = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      rr_ptr       <= '0;
      op_cnt       <= '0;
      bus.rsp_id   <= '0;
      bus.rsp_rslt <= '0;
      bus.rsp_lt   <= 1'b0;
      bus.rsp_err  <= 1'b0;
    end else begin
      if (pop) op_cnt <= op_cnt + CNT_WIDTH'(1);
      if (fire) begin
        bus.rsp_id   <= gnt_id;
        bus.rsp_rslt <= rslt_nxt;
        bus.rsp_lt   <= lt_nxt;
        bus.rsp_err  <= err_nxt;
        rr_ptr       <= ptr_nxt;
      end
      case (state)
        EMPTY: if (fire) state <= FULL;
        FULL:  if (bus.rsp_rdy && !fire) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_zion_rvi_addsub_arb.sv
// Directed bench for zion_rvi_addsub_arb with two requesters and hand-computed results.
module tb_zion_rvi_addsub_arb;
  localparam int CW = 32;
  localparam int NR = 2;

  logic        clk;
  logic        rst;
  logic [15:0] op_cnt;
  int          checks;
  int          errors;

  zion_rvi_addsub_arb_if #(.CPU_WIDTH(CW), .NUM_REQ(NR)) bus ();

  zion_rvi_addsub_arb #(.CPU_WIDTH(CW), .NUM_REQ(NR), .CNT_WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .op_cnt (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic uns,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_op[2*i +: 2]     = op;
    bus.req_unsigned[i]      = uns;
    bus.req_s1[CW*i +: CW]   = a;
    bus.req_s2[CW*i +: CW]   = b;
    bus.req_vld[i]           = 1'b1;
  endtask

  task automatic pop_rsp();
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_vld = '0;
    bus.req_op = '0;
    bus.req_unsigned = '0;
    bus.req_s1 = '0;
    bus.req_s2 = '0;
    bus.rsp_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_vld", bus.rsp_vld, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_rslt", bus.rsp_rslt, 0);
    chk("rst_lt", bus.rsp_lt, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_cnt", op_cnt, 0);
    bus.req_vld = 2'b11;
    #1 chk("rst_rdy", bus.req_rdy, 2'b01);
    bus.req_vld = 2'b00;
    #1 chk("idle_rdy", bus.req_rdy, 2'b00);

    // single add
    set_req(0, 2'b01, 1'b0, 32'd5, 32'd7);
    #1 chk("add_rdy", bus.req_rdy, 2'b01);
    tick();
    bus.req_vld[0] = 1'b0;
    chk("add_vld", bus.rsp_vld, 1);
    chk("add_rslt", bus.rsp_rslt, 12);
    chk("add_lt", bus.rsp_lt, 0);
    chk("add_id", bus.rsp_id, 0);
    chk("add_err", bus.rsp_err, 0);
    pop_rsp();
    chk("add_pop_vld", bus.rsp_vld, 0);
    chk("add_pop_cnt", op_cnt, 1);

    // subtracts
    set_req(1, 2'b10, 1'b0, 32'd3, 32'd5);
    #1 chk("subs_rdy", bus.req_rdy, 2'b10);
    tick();
    bus.req_vld[1] = 1'b0;
    chk("subs_rslt", bus.rsp_rslt, 32'hFFFF_FFFE);
    chk("subs_lt", bus.rsp_lt, 1);
    chk("subs_id", bus.rsp_id, 1);
    pop_rsp();
    chk("subs_cnt", op_cnt, 2);

    set_req(1, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'd1);
    tick();
    bus.req_vld[1] = 1'b0;
    chk("subu_rslt", bus.rsp_rslt, 32'hFFFF_FFFE);
    chk("subu_lt", bus.rsp_lt, 0);
    pop_rsp();

    set_req(1, 2'b10, 1'b0, 32'hFFFF_FFFF, 32'd1);
    tick();
    bus.req_vld[1] = 1'b0;
    chk("subs2_rslt", bus.rsp_rslt, 32'hFFFF_FFFE);
    chk("subs2_lt", bus.rsp_lt, 1);
    pop_rsp();
    chk("subs2_cnt", op_cnt, 4);

    // contention: both always valid, consumer always ready
    set_req(0, 2'b01, 1'b0, 32'd10, 32'd20);
    set_req(1, 2'b10, 1'b0, 32'd100, 32'd1);
    bus.rsp_rdy = 1'b1;
    #1 chk("cont_rdy0", bus.req_rdy, 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) bus.req_vld = 2'b00;
      chk("cont_vld", bus.rsp_vld, 1);
      chk("cont_id", bus.rsp_id, k % 2);
      chk("cont_rslt", bus.rsp_rslt, (k % 2 == 1) ? 99 : 30);
      if (k < 3) chk("cont_rdy", bus.req_rdy, (k % 2 == 1) ? 2'b01 : 2'b10);
    end
    chk("cont_cnt", op_cnt, 7);
    tick();
    bus.rsp_rdy = 1'b0;
    chk("cont_drain_vld", bus.rsp_vld, 0);
    chk("cont_drain_cnt", op_cnt, 8);

    // back-pressure
    set_req(0, 2'b01, 1'b0, 32'd1, 32'd2);
    tick();
    bus.req_vld[0] = 1'b0;
    set_req(1, 2'b10, 1'b0, 32'd50, 32'd8);
    chk("bp_rslt0", bus.rsp_rslt, 3);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_rdy", bus.req_rdy, 2'b00);
      tick();
      chk("bp_vld", bus.rsp_vld, 1);
      chk("bp_rslt", bus.rsp_rslt, 3);
      chk("bp_id", bus.rsp_id, 0);
    end
    bus.rsp_rdy = 1'b1;
    #1 chk("bp_rel_rdy", bus.req_rdy, 2'b10);
    tick();
    bus.req_vld[1] = 1'b0;
    chk("bp_b2b_vld", bus.rsp_vld, 1);
    chk("bp_b2b_id", bus.rsp_id, 1);
    chk("bp_b2b_rslt", bus.rsp_rslt, 42);
    chk("bp_b2b_cnt", op_cnt, 9);
    tick();
    bus.rsp_rdy = 1'b0;
    chk("bp_end_vld", bus.rsp_vld, 0);
    chk("bp_end_cnt", op_cnt, 10);

    // illegal op
    set_req(0, 2'b11, 1'b0, 32'd9, 32'd4);
    tick();
    bus.req_vld[0] = 1'b0;
    chk("ill_err", bus.rsp_err, 1);
    chk("ill_rslt", bus.rsp_rslt, 0);
    chk("ill_lt", bus.rsp_lt, 0);
    chk("ill_vld", bus.rsp_vld, 1);
    pop_rsp();
    chk("ill_cnt", op_cnt, 11);

    // reset while FULL with a pending fire; pointer is at 1 beforehand
    set_req(0, 2'b01, 1'b0, 32'd1, 32'd1);
    tick();
    bus.req_vld[0] = 1'b0;
    chk("rmid_full", bus.rsp_vld, 1);
    set_req(1, 2'b01, 1'b0, 32'd2, 32'd2);
    bus.rsp_rdy = 1'b1;
    #1 chk("rmid_pend_rdy", bus.req_rdy, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_vld = 2'b00;
    bus.rsp_rdy = 1'b0;
    chk("rmid_vld", bus.rsp_vld, 0);
    chk("rmid_cnt", op_cnt, 0);
    chk("rmid_rslt", bus.rsp_rslt, 0);
    bus.req_vld = 2'b11;
    #1 chk("rmid_ptr", bus.req_rdy, 2'b01);
    bus.req_vld = 2'b00;

    // counter wrap
    set_req(0, 2'b01, 1'b0, 32'd1, 32'd1);
    bus.rsp_rdy = 1'b1;
    repeat (65535) tick();
    bus.req_vld = 2'b00;
    tick();
    chk("wrap_pre_cnt", op_cnt, 16'hFFFF);
    chk("wrap_pre_vld", bus.rsp_vld, 0);
    set_req(0, 2'b01, 1'b0, 32'd1, 32'd1);
    tick();
    bus.req_vld = 2'b00;
    chk("wrap_full_cnt", op_cnt, 16'hFFFF);
    tick();
    bus.rsp_rdy = 1'b0;
    chk("wrap_cnt", op_cnt, 0);
    chk("wrap_vld", bus.rsp_vld, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
